adder_response_checker: RTL and testbench
=========================================

ADDER_RESPONSE_CHECKER -- requirements
Module: adder_response_checker

Interface
REQ-001 Parameter SETTLE, default 2, is the number of clock cycles each vector is held before its response is sampled; legal range is 1..15.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level-sampled request to run a full sweep.
REQ-005 a, b, c  output  1 each  operand and carry-in drive to the full adder under check.
REQ-006 sum, carry  input  1 each  response from the full adder under check.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  high while sweep results are valid.
REQ-009 pass  output  1  high when done=1 and no mismatch occurred.
REQ-010 err_count  output  4  number of mismatching vectors in the last sweep, 0..8.
REQ-011 fail_vec  output  8  bit i is set when vector i mismatched.

Function
REQ-012 The block has states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 Vector index idx is 3 bits, and {a,b,c} = idx, so vectors 0..7 are 000,001,...,111 in that order.
REQ-014 In IDLE or DONE, start=1 moves the block to DRIVE with idx=0, clears err_count and fail_vec, and clears done and pass, all in the same edge.
REQ-015 In DRIVE or SAMPLE, start is ignored.
REQ-016 DRIVE lasts exactly SETTLE cycles for each vector, counted by a 4-bit settle counter, and then moves to SAMPLE.
REQ-017 SAMPLE lasts one cycle, in which expected sum = a^b^c and expected carry = (a&b)|(a&c)|(b&c) are compared with the sum and carry inputs.
REQ-018 On a mismatch in either output, err_count increments by 1 and fail_vec[idx] is set at the SAMPLE exit edge.
REQ-019 From SAMPLE with idx<7, idx increments and the block returns to DRIVE.
REQ-020 From SAMPLE with idx=7, the block moves to DONE; idx does not wrap or advance further.
REQ-021 busy=1 exactly in DRIVE and SAMPLE.
REQ-022 done=1 exactly in DONE.
REQ-023 pass = done & (err_count==0); pass and err_count in DONE reflect the final vector's comparison.
REQ-024 Start to done latency: start is sampled at edge N, and done first reads 1 after edge N+8*(SETTLE+1)+1, which is edge N+25 for SETTLE=2.
REQ-025 a, b and c change only on the edge entering DRIVE for a new vector and are stable throughout DRIVE and SAMPLE.
REQ-026 In IDLE, a, b and c are 0; in DONE, a, b and c hold 111.
REQ-027 DONE persists, holding all results, until start=1 or rst=1.
REQ-028 err_count cannot exceed 8 and needs no saturation logic.

Reset
REQ-029 When rst=1 at a rising edge, state becomes IDLE, and idx, the settle counter, a, b, c, busy, done, pass, err_count and fail_vec all become 0.
REQ-030 rst has priority over start and over any in-progress sweep; a sweep interrupted by reset is abandoned and its partial results are discarded.
REQ-031 No output is X after the first reset edge.

Verification
REQ-032 Correct adder model, SETTLE=2, start pulsed one cycle -> busy high for 24 cycles, then done=1, pass=1, err_count=0, fail_vec=8'h00.
REQ-033 Model with carry stuck at 0 -> done=1, pass=0, err_count=4, fail_vec=8'b11101000 (bits 3,5,6,7 set).
REQ-034 Model with sum inverted -> err_count=8, fail_vec=8'hFF, pass=0.
REQ-035 rst asserted one cycle while idx=4 in DRIVE -> the next cycle shows IDLE with all outputs 0, and a fresh start then yields the full 25-cycle sweep.
REQ-036 start held high throughout -> the request is ignored while busy, and the block restarts on the first cycle in DONE, so done is high for exactly one cycle between sweeps.
REQ-037 SETTLE=1 and SETTLE=15 -> start to done latency is 17 and 129 cycles respectively, with correct pass results.

Source files
------------

// File: rtl/adder_response_checker_if.sv
// Start/result handshake plus the operand/response wires of the full adder under check.
interface adder_response_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       sum;
    logic       carry;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    // Environment side: requests sweeps and hosts the adder being checked.
    modport master (
        output start, sum, carry,
        input  a, b, c, busy, done, pass, err_count, fail_vec
    );

    // Checker side.
    modport slave (
        input  start, sum, carry,
        output a, b, c, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/adder_response_checker.sv
// Exhaustive full-adder checker: sweeps all 8 input vectors, holds each for
// SETTLE cycles, samples the response, and reports per-vector mismatches.
module adder_response_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    adder_response_checker_if.slave   bus
);

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned ERR_W    = 4;
    localparam int unsigned NVEC     = 8;

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NVEC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NVEC-1:0]      fail_q, fail_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic                 exp_sum_c;
    logic                 exp_carry_c;
    logic                 mismatch_c;

    // Golden full-adder response for the vector currently driven.
    always_comb begin
        exp_sum_c   = idx_q[2] ^ idx_q[1] ^ idx_q[0];
        exp_carry_c = (idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0]);
        mismatch_c  = (bus.sum != exp_sum_c) || (bus.carry != exp_carry_c);
    end

    // Next-state and next-output logic; outputs derive from the next state so they are registered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    fail_d   = '0;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_d         = err_q + ERR_W'(1);
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    // State and result registers; reset abandons any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // The vector index is the operand drive: {a,b,c} = idx.
    assign bus.a         = idx_q[2];
    assign bus.b         = idx_q[1];
    assign bus.c         = idx_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: three instances (SETTLE = 2, 1, 15) share
// start/rst and a configurable faulty full-adder model.
module tb_adder_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] sum_flip;
    logic [7:0] carry_flip;
    logic       carry_stuck;

    int n_checks = 0;
    int n_fail   = 0;

    adder_response_checker_if if2 ();
    adder_response_checker_if if1 ();
    adder_response_checker_if if15 ();

    adder_response_checker #(.SETTLE(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));
    adder_response_checker #(.SETTLE(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    adder_response_checker #(.SETTLE(15)) dut15 (.clk(clk), .rst(rst), .bus(if15));

    // Full adder under check, with optional injected faults; returns {carry, sum}.
    function automatic logic [1:0] adder_model(input logic [2:0] v, input logic [7:0] sf,
                                               input logic [7:0] cf, input logic cs);
        int   total;
        logic s;
        logic cy;
        total = int'(v[2]) + int'(v[1]) + int'(v[0]);
        s     = ((total % 2) == 1) ^ sf[v];
        cy    = cs ? 1'b0 : ((total >= 2) ^ cf[v]);
        return {cy, s};
    endfunction

    assign if2.start  = start;
    assign if1.start  = start;
    assign if15.start = start;
    assign {if2.carry,  if2.sum}  = adder_model({if2.a,  if2.b,  if2.c},  sum_flip, carry_flip, carry_stuck);
    assign {if1.carry,  if1.sum}  = adder_model({if1.a,  if1.b,  if1.c},  sum_flip, carry_flip, carry_stuck);
    assign {if15.carry, if15.sum} = adder_model({if15.a, if15.b, if15.c}, sum_flip, carry_flip, carry_stuck);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: evaluate the adder on all 8 vectors against arithmetic truth.
    task automatic ref_sweep(output logic [3:0] e, output logic [7:0] fv);
        e  = '0;
        fv = '0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] out;
            int         total;
            v     = 3'(i);
            total = int'(v[2]) + int'(v[1]) + int'(v[0]);
            out   = adder_model(v, sum_flip, carry_flip, carry_stuck);
            if (int'(out[0]) != (total % 2) || int'(out[1]) != (total / 2)) begin
                fv[i] = 1'b1;
                e     = e + 4'd1;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "/busy"}, 32'(if2.busy), 32'd0);
        check_eq({tag, "/done"}, 32'(if2.done), 32'd0);
        check_eq({tag, "/pass"}, 32'(if2.pass), 32'd0);
        check_eq({tag, "/err"},  32'(if2.err_count), 32'd0);
        check_eq({tag, "/fail"}, 32'(if2.fail_vec), 32'd0);
        check_eq({tag, "/abc"},  32'({if2.a, if2.b, if2.c}), 32'd0);
        check_eq({tag, "/busy1"}, 32'(if1.busy | if15.busy), 32'd0);
        check_eq({tag, "/done1"}, 32'(if1.done | if15.done), 32'd0);
    endtask

    // Pulse start for one cycle (caller sits just after a rising edge) and check all instances.
    task automatic run_sweep(input string tag);
        logic [3:0] exp_err;
        logic [7:0] exp_fv;
        int         lat2, lat1, lat15, busy_cnt;
        ref_sweep(exp_err, exp_fv);
        lat2 = 0; lat1 = 0; lat15 = 0; busy_cnt = 0;
        start = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (if2.busy) busy_cnt++;
            if (k <= 25) begin
                check_eq({tag, "/busy_k"}, 32'(if2.busy), 32'(k <= 24));
                check_eq({tag, "/abc_k"}, 32'({if2.a, if2.b, if2.c}),
                         (k <= 24) ? 32'((k - 1) / 3) : 32'd7);
            end
            if (if2.done  && lat2  == 0) lat2  = k;
            if (if1.done  && lat1  == 0) lat1  = k;
            if (if15.done && lat15 == 0) lat15 = k;
        end
        check_eq({tag, "/busy_cycles"}, 32'(busy_cnt), 32'd24);
        check_eq({tag, "/lat2"},  32'(lat2),  32'd25);
        check_eq({tag, "/lat1"},  32'(lat1),  32'd17);
        check_eq({tag, "/lat15"}, 32'(lat15), 32'd129);
        check_eq({tag, "/err2"},  32'(if2.err_count),  32'(exp_err));
        check_eq({tag, "/err1"},  32'(if1.err_count),  32'(exp_err));
        check_eq({tag, "/err15"}, 32'(if15.err_count), 32'(exp_err));
        check_eq({tag, "/fv2"},   32'(if2.fail_vec),   32'(exp_fv));
        check_eq({tag, "/fv1"},   32'(if1.fail_vec),   32'(exp_fv));
        check_eq({tag, "/fv15"},  32'(if15.fail_vec),  32'(exp_fv));
        check_eq({tag, "/pass2"},  32'(if2.pass),  32'(exp_err == 0));
        check_eq({tag, "/pass1"},  32'(if1.pass),  32'(exp_err == 0));
        check_eq({tag, "/pass15"}, 32'(if15.pass), 32'(exp_err == 0));
        check_eq({tag, "/done_hold"}, 32'(if2.done & if1.done & if15.done), 32'd1);
        check_eq({tag, "/abc_done"}, 32'({if2.a, if2.b, if2.c}), 32'd7);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        sum_flip    = '0;
        carry_flip  = '0;
        carry_stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("idle");

        run_sweep("good");

        carry_stuck = 1'b1;
        run_sweep("carry_stuck0");
        check_eq("carry_stuck0/fv_const", 32'(if2.fail_vec), 32'hE8);
        check_eq("carry_stuck0/err_const", 32'(if2.err_count), 32'd4);
        carry_stuck = 1'b0;

        sum_flip = 8'hFF;
        run_sweep("sum_inv");
        check_eq("sum_inv/err_const", 32'(if2.err_count), 32'd8);
        sum_flip = '0;

        for (int r = 0; r < 4; r++) begin
            sum_flip   = 8'($urandom) & 8'($urandom);
            carry_flip = 8'($urandom) & 8'($urandom);
            run_sweep("random");
        end
        sum_flip   = '0;
        carry_flip = '0;

        // Reset in the middle of vector 4 with partial errors accumulated.
        sum_flip = 8'hFF;
        start    = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
        end
        check_eq("midrst/abc_before", 32'({if2.a, if2.b, if2.c}), 32'd4);
        check_eq("midrst/err_before", 32'(if2.err_count), 32'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs("midrst");
        sum_flip = '0;
        run_sweep("after_rst");

        // start held high: restart on first DONE cycle, done high exactly one cycle.
        start = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            @(posedge clk);
            #1;
            if (k == 24) check_eq("hold/done24", 32'(if2.done), 32'd0);
            if (k == 25) begin
                check_eq("hold/done25", 32'(if2.done), 32'd1);
                check_eq("hold/pass25", 32'(if2.pass), 32'd1);
            end
            if (k == 26) begin
                check_eq("hold/done26", 32'(if2.done), 32'd0);
                check_eq("hold/busy26", 32'(if2.busy), 32'd1);
            end
            if (k == 50) check_eq("hold/done50", 32'(if2.done), 32'd1);
            if (k == 51) check_eq("hold/done51", 32'(if2.done), 32'd0);
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
